// File: rtl/pass_lock_ctrl.sv
// Parametrised password-lock controller: multi-digit code entry, door release on
// request drop, consecutive-failure counting and a timed lockout.
module pass_lock_ctrl #(
    parameter int DIGITS      = 4,
    parameter int WIDTH       = 4,
    parameter int MAX_FAIL    = 3,
    parameter int LOCK_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      request,
    input  logic                      confirm,
    input  logic                      digit_valid,
    input  logic [WIDTH-1:0]          digit,
    input  logic [DIGITS*WIDTH-1:0]   pass_code,
    output logic [WIDTH-1:0]          dout,
    output logic                      en_left,
    output logic                      en_right,
    output logic                      locked,
    output logic [3:0]                fail_cnt,
    output logic [2:0]                state
);

    localparam int IW = $clog2(DIGITS);
    localparam int TW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_CONF = 3'd1,
        S_ENTER     = 3'd2,
        S_GRANTED   = 3'd3,
        S_OPEN      = 3'd4,
        S_DENIED    = 3'd5,
        S_LOCKOUT   = 3'd6
    } state_t;

    state_t            state_r, state_s;
    logic [IW-1:0]     idx_r, idx_s;
    logic              mism_r, mism_s, mism_now_s;
    logic [WIDTH-1:0]  last_r, last_s;
    logic [WIDTH-1:0]  dout_r, dout_s;
    logic              en_left_r, en_left_s;
    logic              en_right_r, en_right_s;
    logic              locked_r, locked_s;
    logic [3:0]        fail_r, fail_s;
    logic [TW-1:0]     timer_r, timer_s;

    // Digit 0 of the stored code occupies the most significant slice.
    function automatic logic [WIDTH-1:0] code_digit(input logic [DIGITS*WIDTH-1:0] code,
                                                    input logic [IW-1:0] idx);
        logic [WIDTH-1:0] d;
        d = {WIDTH{1'b0}};
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                d = code[(DIGITS-1-i)*WIDTH +: WIDTH];
            end else begin
                d = d;
            end
        end
        return d;
    endfunction

    // Next-state and next-register-value logic.
    always_comb begin
        state_s    = state_r;
        idx_s      = idx_r;
        mism_s     = mism_r;
        last_s     = last_r;
        dout_s     = dout_r;
        fail_s     = fail_r;
        timer_s    = timer_r;
        en_left_s  = 1'b0;
        en_right_s = 1'b0;
        locked_s   = 1'b0;
        mism_now_s = mism_r | (digit != code_digit(pass_code, idx_r));
        case (state_r)
            S_IDLE: begin
                if (request) begin
                    state_s = S_WAIT_CONF;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_WAIT_CONF: begin
                if (!request) begin
                    state_s = S_IDLE;
                end else if (confirm) begin
                    state_s = S_ENTER;
                    idx_s   = {IW{1'b0}};
                    mism_s  = 1'b0;
                end else begin
                    state_s = S_WAIT_CONF;
                end
            end
            S_ENTER: begin
                if (!request) begin
                    state_s = S_IDLE;
                end else if (digit_valid) begin
                    mism_s = mism_now_s;
                    last_s = digit;
                    if (idx_r == IW'(DIGITS-1)) begin
                        // Whole code consumed: verdict decided only now, never early.
                        if (mism_now_s) begin
                            state_s = S_DENIED;
                            fail_s  = (fail_r == 4'hF) ? fail_r : fail_r + 4'd1;
                        end else begin
                            state_s = S_GRANTED;
                            fail_s  = 4'd0;
                        end
                    end else begin
                        idx_s = idx_r + IW'(1);
                    end
                end else begin
                    state_s = S_ENTER;
                end
            end
            S_GRANTED: begin
                if (!request) begin
                    state_s = S_IDLE;
                end else if (confirm) begin
                    state_s    = S_OPEN;
                    dout_s     = last_r;
                    en_left_s  = ~last_r[0];
                    en_right_s = last_r[0];
                end else begin
                    state_s = S_GRANTED;
                end
            end
            S_OPEN: begin
                if (!request) begin
                    state_s = S_IDLE;
                end else begin
                    en_left_s  = en_left_r;
                    en_right_s = en_right_r;
                end
            end
            S_DENIED: begin
                if (fail_r >= 4'(MAX_FAIL)) begin
                    state_s  = S_LOCKOUT;
                    locked_s = 1'b1;
                    timer_s  = TW'(LOCK_CYCLES-1);
                end else if (!request) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_DENIED;
                end
            end
            S_LOCKOUT: begin
                if (timer_r == {TW{1'b0}}) begin
                    state_s = S_IDLE;
                    fail_s  = 4'd0;
                end else begin
                    locked_s = 1'b1;
                    timer_s  = timer_r - TW'(1);
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            idx_r      <= {IW{1'b0}};
            mism_r     <= 1'b0;
            last_r     <= {WIDTH{1'b0}};
            dout_r     <= {WIDTH{1'b0}};
            en_left_r  <= 1'b0;
            en_right_r <= 1'b0;
            locked_r   <= 1'b0;
            fail_r     <= 4'd0;
            timer_r    <= {TW{1'b0}};
        end else begin
            state_r    <= state_s;
            idx_r      <= idx_s;
            mism_r     <= mism_s;
            last_r     <= last_s;
            dout_r     <= dout_s;
            en_left_r  <= en_left_s;
            en_right_r <= en_right_s;
            locked_r   <= locked_s;
            fail_r     <= fail_s;
            timer_r    <= timer_s;
        end
    end

    assign state    = state_r;
    assign dout     = dout_r;
    assign en_left  = en_left_r;
    assign en_right = en_right_r;
    assign locked   = locked_r;
    assign fail_cnt = fail_r;

endmodule

// File: tb/tb_pass_lock_ctrl.sv
// Bench for pass_lock_ctrl: directed test-plan scenarios followed by random
// traffic, all checked against a session-level reference model.
module tb_pass_lock_ctrl;

    localparam int DIGITS = 4;
    localparam int WIDTH  = 4;
    localparam int MF     = 3;
    localparam int LC     = 8;

    logic                    clk, rst_n, request, confirm, digit_valid;
    logic [WIDTH-1:0]        digit;
    logic [DIGITS*WIDTH-1:0] pass_code;
    logic [WIDTH-1:0]        dout;
    logic                    en_left, en_right, locked;
    logic [3:0]              fail_cnt;
    logic [2:0]              state;

    int checks = 0;
    int errors = 0;

    // Reference model: entered digits kept as a queue, verdict by whole-code compare.
    int               m_state;
    logic [WIDTH-1:0] q[$];
    int               m_fail;
    int               m_lock_left;
    logic [WIDTH-1:0] m_dout;

    pass_lock_ctrl #(.DIGITS(DIGITS), .WIDTH(WIDTH), .MAX_FAIL(MF), .LOCK_CYCLES(LC)) dut (
        .clk(clk), .rst_n(rst_n), .request(request), .confirm(confirm),
        .digit_valid(digit_valid), .digit(digit), .pass_code(pass_code),
        .dout(dout), .en_left(en_left), .en_right(en_right), .locked(locked),
        .fail_cnt(fail_cnt), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] exp_digit(input int i);
        return pass_code[(DIGITS-1-i)*WIDTH +: WIDTH];
    endfunction

    task automatic model_reset();
        m_state = 0; q.delete(); m_fail = 0; m_lock_left = 0; m_dout = '0;
    endtask

    task automatic model_step();
        bit ok;
        case (m_state)
            0: if (request) m_state = 1;
            1: if (!request) m_state = 0;
               else if (confirm) begin m_state = 2; q.delete(); end
            2: if (!request) m_state = 0;
               else if (digit_valid) begin
                   q.push_back(digit);
                   if (q.size() == DIGITS) begin
                       ok = 1'b1;
                       for (int i = 0; i < DIGITS; i++) if (q[i] != exp_digit(i)) ok = 1'b0;
                       if (ok) begin m_state = 3; m_fail = 0; end
                       else begin m_state = 5; m_fail = (m_fail < 15) ? m_fail + 1 : 15; end
                   end
               end
            3: if (!request) m_state = 0;
               else if (confirm) begin m_state = 4; m_dout = q[$]; end
            4: if (!request) m_state = 0;
            5: if (m_fail >= MF) begin m_state = 6; m_lock_left = LC; end
               else if (!request) m_state = 0;
            6: begin
                   m_lock_left--;
                   if (m_lock_left == 0) begin m_state = 0; m_fail = 0; end
               end
            default: m_state = 0;
        endcase
    endtask

    task automatic compare_all();
        check("state",    8'(state),    8'(m_state));
        check("dout",     8'(dout),     8'(m_dout));
        check("en_left",  8'(en_left),  8'(m_state == 4 && !m_dout[0]));
        check("en_right", 8'(en_right), 8'(m_state == 4 && m_dout[0]));
        check("locked",   8'(locked),   8'(m_state == 6));
        check("fail_cnt", 8'(fail_cnt), 8'(m_fail));
    endtask

    task automatic step(input logic r, input logic c, input logic v, input logic [WIDTH-1:0] d);
        request = r; confirm = c; digit_valid = v; digit = d;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic attempt(input logic [DIGITS*WIDTH-1:0] code);
        logic [DIGITS*WIDTH-1:0] c;
        c = code;
        step(1'b1, 1'b0, 1'b0, 4'h0);
        step(1'b1, 1'b1, 1'b0, 4'h0);
        for (int i = 0; i < DIGITS; i++) step(1'b1, 1'b0, 1'b1, c[(DIGITS-1-i)*WIDTH +: WIDTH]);
    endtask

    task automatic mid_cycle_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check({tag, "_en_left"},  8'(en_left),  8'd0);
        check({tag, "_en_right"}, 8'(en_right), 8'd0);
        check({tag, "_locked"},   8'(locked),   8'd0);
        check({tag, "_dout"},     8'(dout),     8'd0);
        check({tag, "_fail"},     8'(fail_cnt), 8'd0);
        check({tag, "_state"},    8'(state),    8'd0);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int cnt;
        logic [WIDTH-1:0] d;
        rst_n = 1'b0; request = 1'b0; confirm = 1'b0; digit_valid = 1'b0;
        digit = '0; pass_code = 16'h1A5C;
        model_reset();
        #7;
        compare_all();
        @(negedge clk) rst_n = 1'b1;

        // Correct code, left door, release on request drop
        attempt(16'h1A5C);
        check("t1_granted", 8'(state), 8'd3);
        step(1'b1, 1'b1, 1'b0, 4'h0);
        check("t1_dout", 8'(dout), 8'hC);
        check("t1_left", 8'(en_left), 8'd1);
        step(1'b0, 1'b0, 1'b0, 4'h0);
        check("t1_release", 8'({en_left, en_right}), 8'd0);

        // Direction select
        pass_code = 16'h1A5D;
        attempt(16'h1A5D);
        step(1'b1, 1'b1, 1'b0, 4'h0);
        check("t2_dout", 8'(dout), 8'hD);
        check("t2_right", 8'(en_right), 8'd1);
        step(1'b0, 1'b0, 1'b0, 4'h0);

        // Lockout after three failures
        pass_code = 16'h1A5C;
        for (int k = 1; k <= 3; k++) begin
            attempt(16'h1A50);
            check("t3_fail", 8'(fail_cnt), 8'(k));
            if (k < 3) step(1'b0, 1'b0, 1'b0, 4'h0);
        end
        step(1'b1, 1'b1, 1'b1, 4'h1);
        cnt = 0;
        for (int i = 0; i < 20 && locked; i++) begin
            cnt++;
            step(1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));
        end
        check("t3_lock_len", 8'(cnt), 8'(LC));
        check("t3_fail_clr", 8'(fail_cnt), 8'd0);
        step(1'b0, 1'b0, 1'b0, 4'h0);

        // Success clears failure history
        for (int k = 0; k < 2; k++) begin
            attempt(16'h1A50);
            step(1'b0, 1'b0, 1'b0, 4'h0);
        end
        check("t4_two", 8'(fail_cnt), 8'd2);
        attempt(16'h1A5C);
        check("t4_clear", 8'(fail_cnt), 8'd0);
        step(1'b0, 1'b0, 1'b0, 4'h0);
        attempt(16'h1A50);
        step(1'b1, 1'b0, 1'b0, 4'h0);
        check("t4_no_lock", 8'(state), 8'd5);
        check("t4_one", 8'(fail_cnt), 8'd1);
        step(1'b0, 1'b0, 1'b0, 4'h0);

        // Abort mid-entry, then a fresh full entry
        step(1'b1, 1'b0, 1'b0, 4'h0);
        step(1'b1, 1'b1, 1'b0, 4'h0);
        step(1'b1, 1'b0, 1'b1, 4'h1);
        step(1'b1, 1'b0, 1'b1, 4'hA);
        step(1'b0, 1'b0, 1'b1, 4'h5);
        check("t5_idle", 8'(state), 8'd0);
        check("t5_fail", 8'(fail_cnt), 8'd1);
        attempt(16'h1A5C);
        check("t5_granted", 8'(state), 8'd3);

        // Asynchronous reset in OPEN and in LOCKOUT
        step(1'b1, 1'b1, 1'b0, 4'h0);
        mid_cycle_reset("t6_open");
        for (int k = 0; k < 3; k++) begin
            attempt(16'h0000);
            step(1'b0, 1'b0, 1'b0, 4'h0);
        end
        check("t6_in_lock", 8'(locked), 8'd1);
        mid_cycle_reset("t6_lock");

        // Random traffic against the model
        for (int s = 0; s < 40; s++) begin
            step(1'b0, 1'b0, 1'b0, 4'h0);
            if (m_state == 0) pass_code = 16'($urandom);
            for (int i = 0; i < 60; i++) begin
                if (m_state == 2 && q.size() < DIGITS && $urandom_range(0, 7) != 0)
                    d = exp_digit(q.size());
                else
                    d = 4'($urandom);
                step($urandom_range(0, 19) != 0, 1'($urandom), 1'($urandom), d);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
